sync_capture_queue: RTL
=======================

SYNC_CAPTURE_QUEUE -- requirements
Module: sync_capture_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each captured word.
REQ-002 SHALL have parameter DEPTH, default 4: number of storage entries; power of two, at least 2.
REQ-003 SHALL have port clock_in, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_in, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port clear_in, input, 1 bit: synchronous flush.
REQ-006 SHALL have port enable_in, input, 1 bit: capture request for data_in this cycle.
REQ-007 SHALL have port data_in, input, DATA_WIDTH bits: word to capture.
REQ-008 SHALL have port ready_in, input, 1 bit: consumer accepts data_out this cycle.
REQ-009 SHALL have port valid_out, output, 1 bit: data_out holds an unconsumed word.
REQ-010 SHALL have port data_out, output, DATA_WIDTH bits: head word, or held last word when valid_out=0.
REQ-011 SHALL have port count_out, output, clog2(DEPTH)+1 bits: number of stored entries.
REQ-012 SHALL have port full_out, output, 1 bit: count_out equals DEPTH.
REQ-013 SHALL have port overflow_out, output, 1 bit: sticky flag; a capture was dropped.

Function
REQ-014 SHALL define push = enable_in and (not full_out or pop); a push writes data_in at the write pointer.
REQ-015 SHALL define pop = valid_out and ready_in; a pop advances the read pointer.
REQ-016 SHALL keep count unchanged on simultaneous push and pop, including when full or when holding one entry.
REQ-017 SHALL wrap read and write pointers modulo DEPTH with no gap.
REQ-018 SHALL drop data_in and set overflow_out when enable_in=1, full_out=1 and no pop; storage SHALL be unchanged.
REQ-019 SHALL present the stored head word one cycle after the push that wrote it into an empty queue (latency 1, bypass disabled).
REQ-020 SHALL hold data_out, when valid_out=0, at the last word presented with valid_out=1 (latch-style hold), never X.
REQ-021 SHALL ignore ready_in when valid_out=0; pop on empty SHALL NOT alter state.
REQ-022 SHALL, on clear_in=1, set count to 0, reset pointers, clear overflow_out and ignore enable_in and ready_in that cycle; the held data_out value is retained.
REQ-023 SHALL keep valid_out, full_out and count_out registered-state-derived, with no combinational path from enable_in or data_in except per REQ-028.

Reset
REQ-024 SHALL, while reset_in=1, force count_out=0, valid_out=0, full_out=0, overflow_out=0, data_out=0 and pointers to 0, independent of clock_in.
REQ-025 SHALL discard all stored entries on reset asserted mid-operation; the first push after deassertion lands in entry 0.
REQ-026 SHALL NOT require storage array contents to be reset.

Configuration
REQ-027 SHALL use macro SYNC_CAPTURE_BYPASS_EN to compile in a zero-latency transparent path.
REQ-028 SHALL, with SYNC_CAPTURE_BYPASS_EN defined and count=0 and enable_in=1 and clear_in=0, drive valid_out=1 and data_out=data_in combinationally; if ready_in=1 the word SHALL NOT be stored and SHALL become the held value; otherwise it SHALL be stored as in REQ-014.
REQ-029 SHALL, without SYNC_CAPTURE_BYPASS_EN, never drive outputs combinationally from enable_in or data_in; latency per REQ-019.

Verification
REQ-030 SHALL cover: DEPTH=4, push 0x11,0x22,0x33,0x44 with ready_in=0 -> full_out=1, count_out=4; pop four -> data_out 0x11,0x22,0x33,0x44 in order, then valid_out=0 with data_out held at 0x44.
REQ-031 SHALL cover: full queue, enable_in=1 data 0x55 with ready_in=0 -> overflow_out=1, count_out=4, 0x55 never emitted; then clear_in=1 -> count_out=0, overflow_out=0.
REQ-032 SHALL cover: full queue, push 0x66 and pop same cycle -> count_out stays 4, 0x66 emitted fifth; six push/pop pairs with pointer wrap -> order preserved.
REQ-033 SHALL cover: reset_in pulsed asynchronously between clock edges with count_out=3 -> all outputs 0 immediately; next push 0x77 emitted first.
REQ-034 SHALL cover: SYNC_CAPTURE_BYPASS_EN defined, empty queue, enable_in=1 data 0x88, ready_in=1 -> valid_out=1 and data_out=0x88 same cycle, count_out stays 0; undefined -> valid_out rises next cycle with 0x88.

Source files
------------

// File: rtl/sync_capture_queue.sv
`default_nettype none
// ============================================================================
// Module      : sync_capture_queue
// Description : Single-clock capture queue. Words offered with enable_in are
//               stored in a DEPTH-entry circular buffer. They are presented
//               in order on data_out/valid_out and consumed with ready_in.
//               When the queue is empty, data_out keeps the last word that
//               was presented (latch-style hold). A capture offered while
//               the queue is full and not draining is dropped, and sets a
//               sticky overflow flag.
// Optional    : SYNC_CAPTURE_BYPASS_EN -- when defined, a capture into an
//               empty queue is presented in the same cycle through a
//               combinational path. If ready_in is also high, the word is
//               consumed directly and never stored.
// Ports       : clock_in     - clock; all state changes on its rising edge
//               reset_in     - asynchronous active-high reset
//               clear_in     - synchronous flush (pointers, count, overflow)
//               enable_in    - capture request for data_in
//               data_in      - word to capture
//               ready_in     - consumer accepts data_out this cycle
//               valid_out    - data_out holds an unconsumed word
//               data_out     - head word, or held last word when idle
//               count_out    - number of stored entries
//               full_out     - count_out == DEPTH
//               overflow_out - sticky: a capture was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module sync_capture_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4   // power of two, >= 2
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic                    clear_in,
  input  logic                    enable_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [$clog2(DEPTH):0]  count_out,
  output logic                    full_out,
  output logic                    overflow_out
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

  // Storage and bookkeeping state
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic                  r_overflow;
  // Registered copy of the word on data_out. It tracks the head entry while
  // the queue is non-empty and simply stops updating once the queue drains,
  // which gives the hold behaviour without extra muxing on the output.
  logic [DATA_WIDTH-1:0] r_data_hold;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_bypass;
  logic                  w_bypass_take;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [c_ptr_w-1:0]    w_rd_next;
  logic [c_ptr_w-1:0]    w_wr_next;
  logic [c_cnt_w-1:0]    w_count_next;
  logic [DATA_WIDTH-1:0] w_head_next;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_depth_cnt);

`ifdef SYNC_CAPTURE_BYPASS_EN
  // Transparent path for a capture into an empty queue. Reset is included
  // so that the outputs read zero for the whole time reset is asserted.
  assign w_bypass      = w_empty & enable_in & ~clear_in & ~reset_in;
  assign w_bypass_take = w_bypass & ready_in;
`else
  assign w_bypass      = 1'b0;
  assign w_bypass_take = 1'b0;
`endif

  // A pop only ever consumes a stored entry. A word that is consumed
  // directly through the bypass path is excluded from the push, so it never
  // touches storage.
  assign w_pop  = ~w_empty & ready_in & ~clear_in;
  assign w_push = enable_in & ~clear_in & (~w_full | w_pop) & ~w_bypass_take;
  assign w_drop = enable_in & ~clear_in & w_full & ~w_pop;

  // Pointers are log2(DEPTH) bits wide, so natural overflow gives the
  // modulo-DEPTH wrap with no gap.
  assign w_rd_next = w_pop  ? r_rd_ptr + c_ptr_w'(1) : r_rd_ptr;
  assign w_wr_next = w_push ? r_wr_ptr + c_ptr_w'(1) : r_wr_ptr;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_cnt_w'(1);
      2'b01:   w_count_next = r_count - c_cnt_w'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Head word for the next cycle. The word being written this cycle can be
  // the next head only when it becomes the single remaining entry. That is
  // exactly the case where the write slot equals the next read slot, and the
  // memory has not yet been updated, so it is forwarded from data_in.
  assign w_head_next = (w_push && (r_wr_ptr == w_rd_next)) ? data_in
                                                           : r_mem[w_rd_next];

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_data_hold <= '0;
    end else if (clear_in) begin
      // Flush: the held output word is deliberately left untouched.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_bypass_take) begin
        r_data_hold <= data_in;
      end else if (w_count_next != '0) begin
        r_data_hold <= w_head_next;
      end
    end
  end

  // Storage array is not reset; entries are only read once written.
  always_ff @(posedge clock_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  assign valid_out    = ~w_empty | w_bypass;
  assign data_out     = w_bypass ? data_in : r_data_hold;
  assign count_out    = r_count;
  assign full_out     = w_full;
  assign overflow_out = r_overflow;

endmodule
`default_nettype wire
